// File: rtl/chan_router_pkg.sv
// Shared encodings for the channel command router.
// States, error codes and the fixed words of the synthetic error packet.
package chan_router_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FWD_CMD,
      WAIT_RESP,
      DRAIN_BAD,
      SEND_RSN,
      SEND_ERR
   } state_t;

   localparam logic [3:0]  ERR_NONE     = 4'd0;
   localparam logic [3:0]  ERR_BAD_DEST = 4'd1;
   localparam logic [3:0]  ERR_TIMEOUT  = 4'd2;
   localparam logic [7:0]  ERR_TAG      = 8'hEE;
   localparam logic [31:0] RSN_WORD     = 32'h0;

   function automatic logic [7:0] sat_add(
      input logic [7:0] v,
      input logic [4:0] n
   );
      logic [8:0] s;
      s = {1'b0, v} + {4'b0, n};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [31:0] err_word(
      input logic [3:0] code,
      input logic [3:0] sel
   );
      return {ERR_TAG, 4'h0, code, 12'h000, sel};
   endfunction

endpackage

// File: rtl/chan_resp_timer.sv
// Response-wait timer: counts while enabled and flags expiry
// at TIMEOUT_CYCLES-1, holding there until cleared.
module chan_resp_timer #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TIMER_W        = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [TIMER_W-1:0] cnt;

   assign expired = (cnt == TIMER_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/chan_cmd_router.sv
// Routes command packets to one of NUM_CHAN links and returns the reply,
// substituting an error packet on bad destination or response timeout.
module chan_cmd_router
   import chan_router_pkg::*;
#(
   parameter int NUM_CHAN       = 5,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TIMER_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              cmd_data,
   input  logic [3:0]               cmd_dest,
   input  logic                     cmd_last,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   output logic [31:0]              ch_tx_data,
   output logic                     ch_tx_last,
   output logic [NUM_CHAN-1:0]      ch_tx_valid,
   input  logic [NUM_CHAN-1:0]      ch_tx_ready,
   input  logic [32*NUM_CHAN-1:0]   ch_rx_data,
   input  logic [NUM_CHAN-1:0]      ch_rx_last,
   input  logic [NUM_CHAN-1:0]      ch_rx_valid,
   output logic [NUM_CHAN-1:0]      ch_rx_ready,
   output logic [31:0]              resp_data,
   output logic                     resp_last,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [7:0]               timeout_cnt,
   output logic [7:0]               bad_dest_cnt,
   output logic [7:0]               stale_cnt
);

   state_t              state;
   logic [3:0]          sel;
   logic [3:0]          err_code;
   logic                got_first;
   logic [NUM_CHAN-1:0] hit;
   logic [31:0]         rx_data_sel;
   logic                tx_rdy_sel;
   logic                rx_vld_sel;
   logic                rx_last_sel;
   logic                cmd_acc;
   logic                rx_acc;
   logic                tmr_clr;
   logic                tmr_en;
   logic                expired;

   always_comb begin
      hit         = '0;
      rx_data_sel = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         hit[i] = (sel == 4'(i));
         if (hit[i]) rx_data_sel = ch_rx_data[32*i +: 32];
      end
   end

   assign tx_rdy_sel  = |(ch_tx_ready & hit);
   assign rx_vld_sel  = |(ch_rx_valid & hit);
   assign rx_last_sel = |(ch_rx_last & hit);

   // Outputs are gated by rst_n so they drop the instant reset asserts.
   always_comb begin
      cmd_ready   = 1'b0;
      ch_tx_valid = '0;
      ch_tx_data  = cmd_data;
      ch_tx_last  = cmd_last;
      ch_rx_ready = '0;
      resp_valid  = 1'b0;
      resp_data   = '0;
      resp_last   = 1'b0;
      if (rst_n) begin
         unique case (state)
            IDLE: ch_rx_ready = '1;
            FWD_CMD: begin
               ch_tx_valid = hit & {NUM_CHAN{cmd_valid}};
               cmd_ready   = tx_rdy_sel;
            end
            WAIT_RESP: begin
               resp_valid  = rx_vld_sel;
               ch_rx_ready = hit & {NUM_CHAN{resp_ready}};
               resp_data   = rx_data_sel;
               resp_last   = rx_last_sel;
            end
            DRAIN_BAD: cmd_ready = 1'b1;
            SEND_RSN: begin
               resp_valid = 1'b1;
               resp_data  = RSN_WORD;
            end
            SEND_ERR: begin
               resp_valid = 1'b1;
               resp_last  = 1'b1;
               resp_data  = err_word(err_code, sel);
            end
            default: ;
         endcase
      end
   end

   assign cmd_acc = cmd_valid & cmd_ready;
   assign rx_acc  = (state == WAIT_RESP) & resp_valid & resp_ready;
   assign tmr_clr = (state == FWD_CMD) & cmd_acc & cmd_last;
   assign tmr_en  = (state == WAIT_RESP) & ~got_first;

   chan_resp_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMER_W       (TIMER_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmr_clr),
      .en     (tmr_en),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sel          <= '0;
         err_code     <= ERR_NONE;
         got_first    <= 1'b0;
         timeout_cnt  <= '0;
         bad_dest_cnt <= '0;
         stale_cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               stale_cnt <= sat_add(stale_cnt,
                                    5'($countones(ch_rx_valid)));
               if (cmd_valid) begin
                  sel   <= cmd_dest;
                  state <= (cmd_dest < 4'(NUM_CHAN)) ? FWD_CMD
                                                     : DRAIN_BAD;
               end
            end
            FWD_CMD: begin
               if (cmd_acc && cmd_last) begin
                  got_first <= 1'b0;
                  state     <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               // An accepted beat beats a coincident expiry.
               if (rx_acc) begin
                  got_first <= 1'b1;
                  if (resp_last) state <= IDLE;
               end else if (expired && !got_first) begin
                  err_code <= ERR_TIMEOUT;
                  state    <= SEND_RSN;
               end
            end
            DRAIN_BAD: begin
               if (cmd_valid && cmd_last) begin
                  err_code     <= ERR_BAD_DEST;
                  bad_dest_cnt <= sat_add(bad_dest_cnt, 5'd1);
                  state        <= SEND_RSN;
               end
            end
            SEND_RSN: begin
               if (resp_ready) state <= SEND_ERR;
            end
            SEND_ERR: begin
               if (resp_ready) begin
                  if (err_code == ERR_TIMEOUT)
                     timeout_cnt <= sat_add(timeout_cnt, 5'd1);
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chan_cmd_router.sv
// Scoreboard bench for chan_cmd_router: drivers queue expected beats,
// a negedge monitor pops and compares every transfer it sees.
module tb_chan_cmd_router;

   localparam int NCH = 5;
   localparam int TO  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       cmd_data = '0;
   logic [3:0]        cmd_dest = '0;
   logic              cmd_last = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [31:0]       ch_tx_data;
   logic              ch_tx_last;
   logic [NCH-1:0]    ch_tx_valid;
   logic [NCH-1:0]    ch_tx_ready = '1;
   logic [32*NCH-1:0] ch_rx_data = '0;
   logic [NCH-1:0]    ch_rx_last = '0;
   logic [NCH-1:0]    ch_rx_valid = '0;
   logic [NCH-1:0]    ch_rx_ready;
   logic [31:0]       resp_data;
   logic              resp_last;
   logic              resp_valid;
   logic              resp_ready = 1'b1;
   logic [7:0]        timeout_cnt;
   logic [7:0]        bad_dest_cnt;
   logic [7:0]        stale_cnt;

   always #5 clk = ~clk;

   chan_cmd_router #(
      .NUM_CHAN      (NCH),
      .TIMEOUT_CYCLES(TO),
      .TIMER_W       (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_data    (cmd_data),
      .cmd_dest    (cmd_dest),
      .cmd_last    (cmd_last),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .ch_tx_data  (ch_tx_data),
      .ch_tx_last  (ch_tx_last),
      .ch_tx_valid (ch_tx_valid),
      .ch_tx_ready (ch_tx_ready),
      .ch_rx_data  (ch_rx_data),
      .ch_rx_last  (ch_rx_last),
      .ch_rx_valid (ch_rx_valid),
      .ch_rx_ready (ch_rx_ready),
      .resp_data   (resp_data),
      .resp_last   (resp_last),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .timeout_cnt (timeout_cnt),
      .bad_dest_cnt(bad_dest_cnt),
      .stale_cnt   (stale_cnt)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] respq[$];
   logic [36:0] txq[$];
   logic [3:0]  exp_ch = '0;
   bit          bp_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (resp_valid && resp_ready) begin
            if (respq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL resp_extra: got %h last %b, none expected",
                        resp_data, resp_last);
            end else begin
               check("resp_beat", {31'b0, resp_last, resp_data},
                     {31'b0, respq.pop_front()});
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (ch_tx_valid[i] && ch_tx_ready[i]) begin
               if (txq.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL tx_extra: ch %0d data %h", i, ch_tx_data);
               end else begin
                  check("tx_beat", {27'b0, 4'(i), ch_tx_last, ch_tx_data},
                        {27'b0, txq.pop_front()});
               end
            end
         end
         if (ch_tx_valid != '0) begin
            check("tx_onehot", 64'(ch_tx_valid), 64'(5'd1 << exp_ch));
            check("cmd_ready_track", 64'(cmd_ready),
                  64'(ch_tx_ready[exp_ch]));
         end
      end
   end

   task automatic wait_cmd(input string name);
      int w;
      bit acc;
      w = 0;
      acc = 1'b0;
      while (!acc && w < 200) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         w++;
      end
      if (!acc) check(name, 64'(acc), 64'd1);
   endtask

   task automatic cmd_pkt(input logic [3:0] dest, input int n,
                          input logic [31:0] base, input bit exp_tx);
      for (int b = 0; b < n; b++) begin
         cmd_valid = 1'b1;
         cmd_dest  = (b == 0) ? dest : 4'hF;
         cmd_data  = base + 32'(b);
         cmd_last  = (b == n - 1);
         if (exp_tx) txq.push_back({dest, cmd_last, cmd_data});
         wait_cmd("cmd_stall");
      end
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
   endtask

   task automatic rx_beat(input int ch, input logic [31:0] d,
                          input logic l);
      int w;
      bit acc;
      ch_rx_valid[ch] = 1'b1;
      ch_rx_last[ch]  = l;
      ch_rx_data[ch*32 +: 32] = d;
      w = 0;
      acc = 1'b0;
      while (!acc && w < 200) begin
         @(negedge clk);
         acc = ch_rx_ready[ch];
         @(posedge clk);
         #1;
         w++;
      end
      if (!acc) check("rx_stall", 64'(acc), 64'd1);
      ch_rx_valid[ch] = 1'b0;
      ch_rx_last[ch]  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int w;
      w = 0;
      while ((respq.size() != 0 || txq.size() != 0) && w < 100) begin
         @(posedge clk);
         w++;
      end
      check(name, 64'(respq.size() + txq.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int zrun;
      #12;
      check("rst_outs", {cmd_ready, ch_tx_valid, ch_rx_ready, resp_valid},
            64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_rx_ready", 64'(ch_rx_ready), 64'h1F);
      check("idle_cmd_resp", {cmd_ready, resp_valid}, 64'd0);
      check("cnt_reset", {timeout_cnt, bad_dest_cnt, stale_cnt}, 64'd0);
      @(posedge clk);
      #1;

      exp_ch = 4'd2;
      respq.push_back({1'b0, 32'h11});
      respq.push_back({1'b1, 32'h22});
      cmd_pkt(4'd2, 4, 32'hA000_0000, 1'b1);
      rx_beat(2, 32'h11, 1'b0);
      rx_beat(2, 32'h22, 1'b1);
      wait_drain("route_ch2");

      exp_ch = 4'hF;
      respq.push_back({1'b0, 32'h0});
      respq.push_back({1'b1, 32'hEE01_0007});
      cmd_pkt(4'd7, 4, 32'hB000_0000, 1'b0);
      wait_drain("bad_dest");
      check("bad_dest_cnt", 64'(bad_dest_cnt), 64'd1);

      exp_ch = 4'd1;
      respq.push_back({1'b0, 32'h0});
      respq.push_back({1'b1, 32'hEE02_0001});
      cmd_pkt(4'd1, 1, 32'hC000_0000, 1'b1);
      wait_drain("timeout");
      check("timeout_cnt", 64'(timeout_cnt), 64'd1);
      check("stale_pre", 64'(stale_cnt), 64'd0);
      rx_beat(1, 32'h5151_0001, 1'b0);
      rx_beat(1, 32'h5151_0002, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("stale_cnt", 64'(stale_cnt), 64'd2);

      exp_ch = 4'd4;
      cmd_pkt(4'd4, 1, 32'hD000_0000, 1'b1);
      repeat (TO - 1) @(posedge clk);
      #1;
      respq.push_back({1'b1, 32'hABCD_0004});
      rx_beat(4, 32'hABCD_0004, 1'b1);
      wait_drain("expiry_edge");
      repeat (20) @(posedge clk);
      #1;
      check("timeout_cnt_edge", 64'(timeout_cnt), 64'd1);

      exp_ch = 4'd0;
      respq.push_back({1'b0, 32'h0A0A_0001});
      respq.push_back({1'b0, 32'h0A0A_0002});
      respq.push_back({1'b1, 32'h0A0A_0003});
      bp_on = 1'b1;
      zrun = 0;
      fork
         begin
            cmd_pkt(4'd0, 6, 32'hE000_0000, 1'b1);
            rx_beat(0, 32'h0A0A_0001, 1'b0);
            rx_beat(0, 32'h0A0A_0002, 1'b0);
            rx_beat(0, 32'h0A0A_0003, 1'b1);
            bp_on = 1'b0;
         end
         begin
            while (bp_on) begin
               @(posedge clk);
               #1;
               ch_tx_ready[0] = 1'($urandom_range(0, 1));
               resp_ready = (zrun >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
               zrun = resp_ready ? 0 : zrun + 1;
            end
         end
      join
      ch_tx_ready = '1;
      resp_ready  = 1'b1;
      wait_drain("backpressure");

      exp_ch    = 4'd3;
      cmd_valid = 1'b1;
      cmd_dest  = 4'd3;
      cmd_data  = 32'hF000_0001;
      cmd_last  = 1'b0;
      txq.push_back({4'd3, 1'b0, 32'hF000_0001});
      wait_cmd("rst_beat1");
      cmd_data = 32'hF000_0002;
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", {cmd_ready, ch_tx_valid, ch_rx_ready, resp_valid},
            64'd0);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_cnt_clear", {timeout_cnt, bad_dest_cnt, stale_cnt}, 64'd0);
      respq.push_back({1'b1, 32'h3333_0003});
      cmd_pkt(4'd3, 2, 32'h3000_0000, 1'b1);
      rx_beat(3, 32'h3333_0003, 1'b1);
      wait_drain("post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
